// File: rtl/buf_page_reader.sv
// buf_page_reader: streams Length bytes from page buffer port B over valid/ready (optional BUF_READER_CHECKSUM_EN)
module buf_page_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [LEN_W-1:0]  Length,
  input  logic              Abort,
  output logic [ADDR_W-1:0] BufAddr,
  output logic              BufClockEn,
  output logic              BufWr,
  input  logic [DATA_W-1:0] BufQ,
  output logic [DATA_W-1:0] OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done,
  output logic [15:0]       Checksum
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic infl_q, infl_d, busy_q, busy_d, done_q, done_d;
  logic pop, push, issue, go;
  // Next-state: read credit, 2-entry FIFO bookkeeping and the IDLE/RUN/DRAIN sequencing
  always_comb begin
    pop    = (cnt_q != 2'd0) && OutReady;
    push   = infl_q;
    issue  = (state_q == RUN) && !Abort && ({1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop} < 3'd2);
    go     = (state_q == IDLE) && Start && !Abort;
    state_d = state_q;
    addr_d = issue ? addr_q + 1'b1 : addr_q;
    rem_d  = issue ? rem_q - 1'b1 : rem_q;
    infl_d = issue;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = (cnt_q == 2'd2 && pop) ? tail_q :
             (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) ? BufQ : head_q;
    tail_d = (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) ? BufQ : tail_q;
    done_d = 1'b0;
    if (Abort) begin
      state_d = IDLE;
      infl_d  = 1'b0;
      cnt_d   = 2'd0;
    end else if (go) begin
      addr_d  = StartAddr;
      rem_d   = Length;
      state_d = (Length != '0) ? RUN : IDLE;
      done_d  = (Length == '0);
    end else if (issue && rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
      state_d = DRAIN;
    end else if (state_q == DRAIN && !infl_q && cnt_d == 2'd0) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end
  // State and registered outputs, cleared asynchronously
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      infl_q  <= 1'b0;
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign BufAddr    = addr_q;
  assign BufClockEn = issue;
  assign BufWr      = 1'b0;
  assign OutData    = head_q;
  assign OutValid   = (cnt_q != 2'd0);
  assign Busy       = busy_q;
  assign Done       = done_q;
`ifdef BUF_READER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  // Wrap-around sum of accepted bytes; cleared by Start or Abort, held after Done
  always_comb sum_d = (Abort || go) ? 16'd0 : pop ? sum_q + {{(16-DATA_W){1'b0}}, head_q} : sum_q;
  // Checksum accumulator register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) sum_q <= 16'd0;
    else sum_q <= sum_d;
  end
  assign Checksum = sum_q;
`else
  assign Checksum = 16'd0;
`endif
endmodule

// File: tb/tb_buf_page_reader.sv
// tb_buf_page_reader: scoreboard bench for buf_page_reader with a registered-read buffer model
module tb_buf_page_reader;
  logic Clock = 0, ResetN = 0, Start = 0, Abort = 0, OutReady = 1;
  logic [10:0] StartAddr = 0;
  logic [11:0] Length = 0;
  logic [10:0] BufAddr;
  logic BufClockEn, BufWr, OutValid, Busy, Done;
  logic [7:0] BufQ = 0, OutData;
  logic [15:0] Checksum;
  int total = 0, bad = 0, done_cnt = 0, acc_cnt = 0, phase = 0;
  logic [7:0] mem [2048];
  logic [7:0] exp_q[$];
  logic [10:0] addr_q[$];
  logic [15:0] exp_sum;
  logic toggle = 0, stall = 0;
  logic [7:0] stall_data;

  buf_page_reader dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr), .Length(Length),
    .Abort(Abort), .BufAddr(BufAddr), .BufClockEn(BufClockEn), .BufWr(BufWr), .BufQ(BufQ),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy), .Done(Done),
    .Checksum(Checksum)
  );

  always #5 Clock = ~Clock;

  // Page buffer port B: one-cycle registered read
  always @(posedge Clock) if (BufClockEn) BufQ <= mem[BufAddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read addresses, accepted bytes, hold-while-stalled, Done pulses
  always @(negedge Clock) begin
    if (!ResetN) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid", OutValid, 1);
        chk("hold_data", OutData, stall_data);
      end
      if (BufClockEn) begin
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read: addr=%0d with none expected", BufAddr);
        end else chk("read_addr", BufAddr, addr_q.pop_front());
      end
      if (OutValid && OutReady) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %0h with none expected", OutData);
        end else chk("out_byte", OutData, exp_q.pop_front());
      end
      if (Done) done_cnt++;
      stall = OutValid && !OutReady && !Abort;
      stall_data = OutData;
    end
  end

  // OutReady pattern 1,0,0,1 repeating while toggle is set
  initial forever begin
    @(posedge Clock); #2;
    if (toggle) begin
      OutReady = (phase % 4 == 0) || (phase % 4 == 3);
      phase++;
    end
  end

  task automatic expect_xfer(input logic [10:0] a, input int n);
    logic [10:0] idx;
    exp_sum = 0;
    for (int i = 0; i < n; i++) begin
      idx = a + 11'(i);
      exp_q.push_back(mem[idx]);
      addr_q.push_back(idx);
      exp_sum += {8'd0, mem[idx]};
    end
  endtask

  task automatic go(input logic [10:0] a, input logic [11:0] n);
    StartAddr = a; Length = n; Start = 1;
    @(posedge Clock); #1 Start = 0;
  endtask

  task automatic chk_sum(input string name);
`ifdef BUF_READER_CHECKSUM_EN
    chk(name, Checksum, exp_sum);
`else
    chk(name, Checksum, 0);
`endif
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      @(posedge Clock); #1;
    end
    chk({name, "_done_count"}, done_cnt - d0, 1);
    chk({name, "_left_bytes"}, exp_q.size(), 0);
    chk({name, "_left_reads"}, addr_q.size(), 0);
    chk_sum({name, "_checksum"});
  endtask

  task automatic wait_acc(input int a0, input int n);
    for (int i = 0; i < 200 && acc_cnt - a0 < n; i++) begin
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    int d0, a0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_addr", BufAddr, 0);
    chk("rst_en", BufClockEn, 0);
    chk("rst_wr", BufWr, 0);
    chk("rst_data", OutData, 0);
    chk("rst_valid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_sum", Checksum, 0);
    @(posedge Clock); #1 ResetN = 1;
    @(posedge Clock); #1;

    // Basic 4-byte stream with latency and Done timing
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    addr_q = '{11'd0, 11'd1, 11'd2, 11'd3};
    exp_sum = 16'h00AA;
    d0 = done_cnt;
    go(0, 4);
    chk("t1_busy", Busy, 1);
    chk("t1_en_k", BufClockEn, 1);
    chk("t1_valid_k", OutValid, 0);
    @(posedge Clock); #1;
    chk("t1_valid_k1", OutValid, 0);
    @(posedge Clock); #1;
    chk("t1_valid_k2", OutValid, 1);
    chk("t1_data_k2", OutData, 8'h11);
    repeat (3) begin @(posedge Clock); #1; end
    chk("t1_data_k5", OutData, 8'h44);
    chk("t1_done_k5", Done, 0);
    @(posedge Clock); #1;
    chk("t1_done_k6", Done, 1);
    chk("t1_busy_k6", Busy, 0);
    chk("t1_valid_k6", OutValid, 0);
    @(posedge Clock); #1;
    chk("t1_done_k7", Done, 0);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_left", exp_q.size(), 0);
    chk_sum("t1_checksum");

    // Address wrap 2046 -> 1
    exp_q = '{8'h3D, 8'h3C, 8'h11, 8'h22};
    addr_q = '{11'd2046, 11'd2047, 11'd0, 11'd1};
    exp_sum = 16'h00AC;
    go(2046, 4);
    wait_done("wrap");

    // Backpressure with OutReady toggling
    expect_xfer(16, 8);
    phase = 0; toggle = 1;
    go(16, 8);
    wait_done("toggle");
    toggle = 0; OutReady = 1;
    @(posedge Clock); #1;

    // Zero length
    d0 = done_cnt;
    go(50, 0);
    chk("z_done", Done, 1);
    chk("z_busy", Busy, 0);
    chk("z_en", BufClockEn, 0);
    @(posedge Clock); #1;
    chk("z_done_next", Done, 0);
    chk("z_valid", OutValid, 0);
    chk("z_done_count", done_cnt - d0, 1);

    // Abort after 3 accepted bytes
    expect_xfer(100, 10);
    d0 = done_cnt; a0 = acc_cnt;
    go(100, 10);
    wait_acc(a0, 3);
    Abort = 1; OutReady = 0;
    @(posedge Clock); #1 Abort = 0;
    chk("ab_accepted", acc_cnt - a0, 3);
    chk("ab_valid", OutValid, 0);
    chk("ab_busy", Busy, 0);
    chk("ab_sum", Checksum, 0);
    exp_q.delete(); addr_q.delete();
    repeat (3) begin @(posedge Clock); #1; end
    chk("ab_no_done", done_cnt - d0, 0);
    OutReady = 1;
    expect_xfer(5, 2);
    go(5, 2);
    wait_done("after_abort");

    // Reset mid-transfer
    expect_xfer(200, 10);
    d0 = done_cnt; a0 = acc_cnt;
    go(200, 10);
    wait_acc(a0, 4);
    #2 ResetN = 0;
    #1;
    chk("mr_addr", BufAddr, 0);
    chk("mr_en", BufClockEn, 0);
    chk("mr_data", OutData, 0);
    chk("mr_valid", OutValid, 0);
    chk("mr_busy", Busy, 0);
    chk("mr_done", Done, 0);
    chk("mr_sum", Checksum, 0);
    exp_q.delete(); addr_q.delete();
    @(posedge Clock); #1 ResetN = 1;
    repeat (2) begin @(posedge Clock); #1; end
    chk("mr_no_done", done_cnt - d0, 0);
    expect_xfer(2040, 12);
    go(2040, 12);
    wait_done("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
